// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the DSP request arbiter.
//   - Mode codes understood by the complex_dsp datapath.
//   - Controller state encoding.
//   - mode_supported(): true for the modes the datapath implements.
package dsp_ctrl_pkg;

    localparam logic [2:0] MODE_MUL27  = 3'b000;  // single 27x27 multiply
    localparam logic [2:0] MODE_DUAL18 = 3'b001;  // two 18x19 multiplies
    localparam logic [2:0] MODE_PASS   = 3'b111;  // operand pass-through

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Mode codes are zero-extended to 8 bits by the caller, so any set bit
    // above bit 2 makes the code unsupported (mode widths up to 8 bits).
    function automatic logic mode_supported(input logic [7:0] mode);
        return (mode == {5'b0, MODE_MUL27})  ||
               (mode == {5'b0, MODE_DUAL18}) ||
               (mode == {5'b0, MODE_PASS});
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req   : request vector
//   ptr   : highest-priority index for this selection
//   grant : one-hot grant (all-zero when nothing requested)
//   idx   : binary index of the granted requester
//   valid : at least one request present
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    valid
);
    localparam int IDX_W = $clog2(NREQ);

    int cand;

    // Walk the requesters cyclically starting at ptr; first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/dsp_arbiter.sv
// Round-robin front end sharing one complex_dsp datapath between NREQ
// requesters. One operation is in flight at a time:
//   IDLE  : grant one requester (req_ready), latch its operand/mode
//   ISSUE : datapath evaluates dsp_I/dsp_mode, result captured at cycle end
//   RESP  : rsp_* held until rsp_ready
// Unsupported modes skip ISSUE and answer with rsp_err=1, rsp_data=0.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready/req_mode/req_data   packed per-requester request
//   dsp_I, dsp_mode, dsp_result     datapath operand/mode out, result in
//   rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err   response channel
//   op_count                        saturating count of completed responses
module dsp_arbiter
    import dsp_ctrl_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = 74,
    parameter int MODE_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*MODE_W-1:0]   req_mode,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [DATA_W-1:0]        dsp_I,
    output logic [MODE_W-1:0]        dsp_mode,
    input  logic [DATA_W-1:0]        dsp_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic [15:0]              op_count
);
    localparam int IDX_W = $clog2(NREQ);

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    ptr_reg, ptr_next;
    logic [IDX_W-1:0]    id_reg;
    logic [DATA_W-1:0]   dsp_i_reg;
    logic [MODE_W-1:0]   dsp_mode_reg;
    logic [DATA_W-1:0]   rsp_data_reg;
    logic                rsp_err_reg;
    logic [15:0]         op_count_reg;

    logic [NREQ-1:0]     grant;
    logic [IDX_W-1:0]    win_idx;
    logic                win_any;
    logic [MODE_W-1:0]   win_mode;
    logic [DATA_W-1:0]   win_data;
    logic                win_supported;
    logic                accept;
    logic                handshake;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .grant (grant),
        .idx   (win_idx),
        .valid (win_any)
    );

    assign win_mode      = req_mode[int'(win_idx)*MODE_W +: MODE_W];
    assign win_data      = req_data[int'(win_idx)*DATA_W +: DATA_W];
    assign win_supported = mode_supported(8'(win_mode));

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        accept     = 1'b0;
        handshake  = 1'b0;
        // rst_n gate keeps req_ready low while reset is held with requests up.
        req_ready  = (state_reg == IDLE && rst_n) ? grant : '0;
        rsp_valid  = (state_reg == RESP);
        case (state_reg)
            IDLE: begin
                if (win_any) begin
                    accept     = 1'b1;
                    ptr_next   = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    state_next = win_supported ? ISSUE : RESP;
                end
            end
            ISSUE: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            id_reg       <= '0;
            dsp_i_reg    <= '0;
            dsp_mode_reg <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
            op_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            if (accept) begin
                id_reg <= win_idx;
                if (win_supported) begin
                    dsp_i_reg    <= win_data;
                    dsp_mode_reg <= win_mode;
                    rsp_err_reg  <= 1'b0;
                end else begin
                    // Datapath operands stay untouched on the error path.
                    rsp_err_reg  <= 1'b1;
                    rsp_data_reg <= '0;
                end
            end
            if (state_reg == ISSUE) begin
                rsp_data_reg <= dsp_result;
            end
            if (handshake && op_count_reg != 16'hFFFF) begin
                op_count_reg <= op_count_reg + 16'd1;
            end
        end
    end

    assign dsp_I    = dsp_i_reg;
    assign dsp_mode = dsp_mode_reg;
    assign rsp_id   = id_reg;
    assign rsp_data = rsp_data_reg;
    assign rsp_err  = rsp_err_reg;
    assign op_count = op_count_reg;

endmodule

// File: tb/tb_dsp_arbiter.sv
// Self-checking bench for dsp_arbiter. Supplies a behavioural complex_dsp
// model on dsp_result and checks responses against a round-robin model.
module tb_dsp_arbiter;
    localparam int NREQ   = 4;
    localparam int DATA_W = 74;
    localparam int MODE_W = 3;
    localparam int IDX_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NREQ-1:0]         req_valid = '0;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*MODE_W-1:0]  req_mode = '0;
    logic [NREQ*DATA_W-1:0]  req_data = '0;
    logic [DATA_W-1:0]       dsp_I;
    logic [MODE_W-1:0]       dsp_mode;
    logic [DATA_W-1:0]       dsp_result;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b1;
    logic [IDX_W-1:0]        rsp_id;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;
    logic [15:0]             op_count;

    int n_cmp = 0;
    int n_bad = 0;
    int m_ptr = 0;
    int m_count = 0;

    always #5 clk = ~clk;

    dsp_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .MODE_W(MODE_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mode   (req_mode),
        .req_data   (req_data),
        .dsp_I      (dsp_I),
        .dsp_mode   (dsp_mode),
        .dsp_result (dsp_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .op_count   (op_count)
    );

    // Behavioural complex_dsp datapath.
    function automatic logic [DATA_W-1:0] dsp_model(input logic [MODE_W-1:0] m,
                                                    input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        r = '0;
        case (m)
            3'b000: r[53:0] = 54'(x[53:27]) * 54'(x[26:0]);
            3'b001: begin
                r[36:0]  = 37'(x[17:0])  * 37'(x[36:18]);
                r[73:37] = 37'(x[54:37]) * 37'(x[73:55]);
            end
            3'b111: r = x;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign dsp_result = dsp_model(dsp_mode, dsp_I);

    function automatic int rr_model(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [MODE_W-1:0] m, input logic [DATA_W-1:0] d);
        req_mode[k*MODE_W +: MODE_W] = m;
        req_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        m_ptr = 0;
        m_count = 0;
    endtask

    // Presents vld in IDLE, records the grant, then waits (bounded) for rsp_valid.
    // lat = cycles from the accept edge until rsp_valid is seen.
    task automatic run_txn(input logic [NREQ-1:0] vld, input bit keep,
                           output logic [NREQ-1:0] gnt, output int lat);
        req_valid = vld;
        #1;
        gnt = req_ready;
        tick();
        if (!keep) req_valid = '0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        req_valid = '1;
        rsp_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (dsp_I !== '0) begin n_bad++; $display("FAIL reset_dsp_I: got %h expected 0", dsp_I); end
        n_cmp++; if (dsp_mode !== '0) begin n_bad++; $display("FAIL reset_dsp_mode: got %h expected 0", dsp_mode); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (rsp_id !== '0) begin n_bad++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        n_cmp++; if (op_count !== 16'd0) begin n_bad++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
        req_valid = '0;
        rst_n = 1'b1;
        tick();
        m_ptr = 0;
        m_count = 0;
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_mul27();
        logic [DATA_W-1:0] d;
        logic [NREQ-1:0] gnt;
        int lat;
        d = '0;
        d[53:27] = 27'd3;
        d[26:0]  = 27'd5;
        set_req(0, 3'b000, d);
        run_txn(4'b0001, 1'b0, gnt, lat);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL mul27_grant: got %b expected 0001", gnt); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mul27_latency: got %0d expected 2", lat); end
        n_cmp++; if (rsp_data[53:0] !== 54'd15) begin n_bad++; $display("FAIL mul27_data: got %0d expected 15", rsp_data[53:0]); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL mul27_id: got %0d expected 0", rsp_id); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL mul27_err: got %b expected 0", rsp_err); end
        tick();
        m_count++;
        m_ptr = 1;
        n_cmp++; if (op_count !== 16'(m_count)) begin n_bad++; $display("FAIL mul27_count: got %0d expected %0d", op_count, m_count); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mul27_rsp_drop: got %b expected 0", rsp_valid); end
        $display("test_mul27: req0 lat=%0d data=%0d", lat, rsp_data[53:0]);
    endtask

    task automatic test_dual18();
        logic [DATA_W-1:0] d;
        logic [NREQ-1:0] gnt;
        int lat;
        d = '0;
        d[17:0]  = 18'd2;
        d[36:18] = 19'd7;
        d[54:37] = 18'd4;
        d[73:55] = 19'd5;
        set_req(2, 3'b001, d);
        run_txn(4'b0100, 1'b0, gnt, lat);
        n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL dual_grant: got %b expected 0100", gnt); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL dual_latency: got %0d expected 2", lat); end
        n_cmp++; if (rsp_data[36:0] !== 37'd14) begin n_bad++; $display("FAIL dual_lo: got %0d expected 14", rsp_data[36:0]); end
        n_cmp++; if (rsp_data[73:37] !== 37'd20) begin n_bad++; $display("FAIL dual_hi: got %0d expected 20", rsp_data[73:37]); end
        n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL dual_id: got %0d expected 2", rsp_id); end
        tick();
        m_count++;
        m_ptr = 3;
        $display("test_dual18: req2 lat=%0d lo=%0d hi=%0d", lat, rsp_data[36:0], rsp_data[73:37]);
    endtask

    task automatic test_unsupported();
        logic [DATA_W-1:0] d, prev_i;
        logic [NREQ-1:0] gnt;
        int lat;
        prev_i = '0;
        prev_i[17:0]  = 18'd2;
        prev_i[36:18] = 19'd7;
        prev_i[54:37] = 18'd4;
        prev_i[73:55] = 19'd5;
        d = DATA_W'({$urandom, $urandom, $urandom});
        set_req(1, 3'b010, d);
        run_txn(4'b0010, 1'b0, gnt, lat);
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL unsup_grant: got %b expected 0010", gnt); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL unsup_latency: got %0d expected 1", lat); end
        n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL unsup_err: got %b expected 1", rsp_err); end
        n_cmp++; if (rsp_data !== '0) begin n_bad++; $display("FAIL unsup_data: got %h expected 0", rsp_data); end
        n_cmp++; if (rsp_id !== 2'd1) begin n_bad++; $display("FAIL unsup_id: got %0d expected 1", rsp_id); end
        n_cmp++; if (dsp_mode !== 3'b001) begin n_bad++; $display("FAIL unsup_dsp_mode: got %b expected 001", dsp_mode); end
        n_cmp++; if (dsp_I !== prev_i) begin n_bad++; $display("FAIL unsup_dsp_I: got %h expected %h", dsp_I, prev_i); end
        tick();
        m_count++;
        m_ptr = 2;
        n_cmp++; if (op_count !== 16'(m_count)) begin n_bad++; $display("FAIL unsup_count: got %0d expected %0d", op_count, m_count); end
        $display("test_unsupported: req1 mode 010 lat=%0d err=%b", lat, rsp_err);
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [NREQ-1:0] gnt;
        int lat, w;
        do_reset();
        for (int k = 0; k < NREQ; k++) set_req(k, 3'b111, DATA_W'(k + 100));
        for (int i = 0; i < 5; i++) begin
            w = rr_model(4'b1111, m_ptr);
            run_txn(4'b1111, 1'b1, gnt, lat);
            n_cmp++; if (w !== exp_order[i] || gnt !== NREQ'(1 << w)) begin n_bad++; $display("FAIL rr_grant_%0d: got %b expected req %0d", i, gnt, exp_order[i]); end
            n_cmp++; if (rsp_id !== IDX_W'(exp_order[i])) begin n_bad++; $display("FAIL rr_id_%0d: got %0d expected %0d", i, rsp_id, exp_order[i]); end
            n_cmp++; if (rsp_data !== DATA_W'(exp_order[i] + 100)) begin n_bad++; $display("FAIL rr_data_%0d: got %0d expected %0d", i, rsp_data, exp_order[i] + 100); end
            tick();
            m_count++;
            m_ptr = (w + 1) % NREQ;
            $display("test_round_robin: op %0d grant=%b id=%0d", i, gnt, rsp_id);
        end
        req_valid = '0;
        n_cmp++; if (op_count !== 16'd5) begin n_bad++; $display("FAIL rr_count: got %0d expected 5", op_count); end
    endtask

    task automatic test_back_pressure();
        logic [DATA_W-1:0] d;
        logic [NREQ-1:0] gnt;
        int lat;
        d = DATA_W'({$urandom, $urandom, $urandom});
        set_req(3, 3'b111, d);
        rsp_ready = 1'b0;
        run_txn(4'b1000, 1'b0, gnt, lat);
        n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL bp_grant: got %b expected 1000", gnt); end
        req_valid = 4'b0111;
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_%0d: got %b expected 1", i, rsp_valid); end
            n_cmp++; if (rsp_data !== d) begin n_bad++; $display("FAIL bp_data_%0d: got %h expected %h", i, rsp_data, d); end
            n_cmp++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL bp_ready_%0d: got %b expected 0000", i, req_ready); end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        m_count++;
        m_ptr = 0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b expected 0", rsp_valid); end
        n_cmp++; if (op_count !== 16'(m_count)) begin n_bad++; $display("FAIL bp_count: got %0d expected %0d", op_count, m_count); end
        $display("test_back_pressure: held 10 cycles, count=%0d", op_count);
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] gnt;
        int lat;
        for (int k = 0; k < NREQ; k++) set_req(k, 3'b000, DATA_W'(k + 7));
        run_txn(4'b0010, 1'b0, gnt, lat);
        tick();
        m_count++;
        m_ptr = 2;
        // Second request from 1 reaches ISSUE, then reset hits.
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_id !== '0) begin n_bad++; $display("FAIL midrst_rsp: got valid=%b err=%b id=%0d expected 0", rsp_valid, rsp_err, rsp_id); end
        n_cmp++; if (dsp_I !== '0 || dsp_mode !== '0) begin n_bad++; $display("FAIL midrst_dsp: got I=%h mode=%b expected 0", dsp_I, dsp_mode); end
        n_cmp++; if (rsp_data !== '0 || op_count !== 16'd0 || req_ready !== '0) begin n_bad++; $display("FAIL midrst_misc: got data=%h count=%0d ready=%b expected 0", rsp_data, op_count, req_ready); end
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
        m_count = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_norsp_%0d: got %b expected 0", i, rsp_valid); end
        end
        run_txn(4'b1111, 1'b0, gnt, lat);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL midrst_ptr: got %b expected 0001", gnt); end
        tick();
        m_count++;
        m_ptr = 1;
        n_cmp++; if (op_count !== 16'(m_count)) begin n_bad++; $display("FAIL midrst_count: got %0d expected %0d", op_count, m_count); end
        $display("test_reset_mid: first grant after reset=%b", gnt);
    endtask

    task automatic test_random();
        logic [MODE_W-1:0] modes [NREQ];
        logic [DATA_W-1:0] datas [NREQ];
        logic [NREQ-1:0] vld, gnt;
        logic [DATA_W-1:0] exp_data;
        int lat, w, d, sel;
        bit sup;
        for (int it = 0; it < 40; it++) begin
            vld = NREQ'($urandom_range(1, 15));
            for (int k = 0; k < NREQ; k++) begin
                sel = $urandom_range(0, 4);
                modes[k] = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b001 : (sel == 2) ? 3'b111 : 3'($urandom);
                datas[k] = DATA_W'({$urandom, $urandom, $urandom});
                set_req(k, modes[k], datas[k]);
            end
            d = $urandom_range(0, 3);
            rsp_ready = (d == 0);
            w = rr_model(vld, m_ptr);
            sup = (modes[w] == 3'b000) || (modes[w] == 3'b001) || (modes[w] == 3'b111);
            exp_data = sup ? dsp_model(modes[w], datas[w]) : '0;
            run_txn(vld, 1'b0, gnt, lat);
            n_cmp++; if (gnt !== NREQ'(1 << w)) begin n_bad++; $display("FAIL rnd_grant_%0d: got %b expected req %0d", it, gnt, w); end
            n_cmp++; if (lat !== (sup ? 2 : 1)) begin n_bad++; $display("FAIL rnd_latency_%0d: got %0d expected %0d", it, lat, sup ? 2 : 1); end
            n_cmp++; if (rsp_id !== IDX_W'(w)) begin n_bad++; $display("FAIL rnd_id_%0d: got %0d expected %0d", it, rsp_id, w); end
            n_cmp++; if (rsp_data !== exp_data) begin n_bad++; $display("FAIL rnd_data_%0d: got %h expected %h", it, rsp_data, exp_data); end
            n_cmp++; if (rsp_err !== !sup) begin n_bad++; $display("FAIL rnd_err_%0d: got %b expected %b", it, rsp_err, !sup); end
            for (int j = 0; j < d; j++) begin
                tick();
                n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rnd_hold_%0d: got %b expected 1", it, rsp_valid); end
            end
            rsp_ready = 1'b1;
            tick();
            m_count++;
            m_ptr = (w + 1) % NREQ;
            n_cmp++; if (op_count !== 16'(m_count) || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_done_%0d: got count=%0d valid=%b expected %0d/0", it, op_count, rsp_valid, m_count); end
            $display("test_random: it=%0d vld=%b win=%0d mode=%b lat=%0d stall=%0d", it, vld, w, modes[w], lat, d);
        end
    endtask

    initial begin
        test_reset();
        test_mul27();
        test_dual18();
        test_unsupported();
        test_round_robin();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
